memory_dual_port: RTL and testbench



---
 rtl/memory_dual_port.sv | 116 +++++++++++
 tb/tb_memory_dual_port.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_dual_port.sv
// Simple dual-port synchronous RAM: one write port with byte enables, one registered read port,
// and a clear engine that sweeps every word to INIT_VALUE while busy is high.
module memory_dual_port #(
  parameter int                AWIDTH     = 5,
  parameter int                DWIDTH     = 8,
  parameter int                RD_LATENCY = 1,
  parameter int                RDW_MODE   = 0,
  parameter logic [DWIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  output logic                busy,
  input  logic                wr,
  input  logic [AWIDTH-1:0]   waddr,
  input  logic [DWIDTH-1:0]   wdata,
  input  logic [DWIDTH/8-1:0] wbe,
  input  logic                rd,
  input  logic [AWIDTH-1:0]   raddr,
  output logic [DWIDTH-1:0]   rdata,
  output logic                rvalid
);

  localparam int DEPTH  = 2 ** AWIDTH;
  localparam int NBYTES = DWIDTH / 8;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state;
  logic [AWIDTH-1:0]  cnt;
  logic [DWIDTH-1:0]  mem [DEPTH];
  logic [DWIDTH-1:0]  merged;
  logic [DWIDTH-1:0]  rd_word;
  logic               rd_en;
  logic               v1;
  logic [DWIDTH-1:0]  d1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Existing word at waddr with the enabled bytes replaced; also feeds write-first reads.
  always_comb begin
    merged = mem[waddr];
    for (int i = 0; i < NBYTES; i++) begin
      if (wbe[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (busy) mem[cnt] <= INIT_VALUE;
    else if (wr) mem[waddr] <= merged;
  end

  assign rd_en   = rd && !busy;
  assign rd_word = (RDW_MODE == 1 && wr && waddr == raddr) ? merged : mem[raddr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= rd_en;
      if (rd_en) d1 <= rd_word;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic              v2;
      logic [DWIDTH-1:0] d2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end

      assign rvalid = v2;
      assign rdata  = d2;
    end else begin : g_lat1
      assign rvalid = v1;
      assign rdata  = d1;
    end
  endgenerate

endmodule

// File: tb/tb_memory_dual_port.sv
// Bench for memory_dual_port: two instances (latency 1 / read-first, latency 2 / write-first)
// share stimulus and are compared against a transaction-level model of the RAM.
module tb_memory_dual_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        wr = 1'b0;
  logic [4:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  wbe = '0;
  logic        rd = 1'b0;
  logic [4:0]  raddr = '0;
  logic        busy_a, busy_b, rvalid_a, rvalid_b;
  logic [15:0] rdata_a, rdata_b;

  int n_tests = 0;
  int n_fail = 0;
  bit auto_chk = 1'b0;

  always #5 clk = ~clk;

  memory_dual_port #(.AWIDTH(5), .DWIDTH(16), .RD_LATENCY(1), .RDW_MODE(0), .INIT_VALUE(16'hFFFF)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy_a), .wr(wr), .waddr(waddr), .wdata(wdata),
    .wbe(wbe), .rd(rd), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a));

  memory_dual_port #(.AWIDTH(5), .DWIDTH(16), .RD_LATENCY(2), .RDW_MODE(1), .INIT_VALUE(16'h00FF)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy_b), .wr(wr), .waddr(waddr), .wdata(wdata),
    .wbe(wbe), .rd(rd), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b));

  // Reference model: k=0 mirrors dut_a, k=1 mirrors dut_b.
  typedef struct { int k; int due; logic [15:0] data; } pend_t;
  logic [15:0] mem_m [2][32];
  pend_t       pq[$];
  logic [15:0] last_m [2];
  bit          valid_m [2];
  bit          busy_m;
  int          cnt_m;
  int          edge_n = 0;

  function automatic int lat_of(int k);  return (k == 0) ? 1 : 2; endfunction
  function automatic bit wfirst(int k);  return k == 1; endfunction
  function automatic logic [15:0] init_of(int k); return (k == 0) ? 16'hFFFF : 16'h00FF; endfunction
  function automatic logic [15:0] merge(logic [15:0] old, logic [15:0] d, logic [1:0] be);
    return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
  endfunction

  task automatic model_reset();
    busy_m = 1'b0;
    cnt_m  = 0;
    pq.delete();
    for (int k = 0; k < 2; k++) begin
      last_m[k]  = '0;
      valid_m[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [15:0] old_r, new_w, val;
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      if (!busy_m) begin
        old_r = mem_m[k][raddr];
        new_w = merge(mem_m[k][waddr], wdata, wbe);
        val   = (wfirst(k) && wr && waddr == raddr) ? new_w : old_r;
        if (rd) pq.push_back('{k: k, due: edge_n + lat_of(k) - 1, data: val});
        if (wr) mem_m[k][waddr] = new_w;
      end else begin
        mem_m[k][cnt_m] = init_of(k);
      end
    end
    if (!busy_m) begin
      if (clr) begin
        busy_m = 1'b1;
        cnt_m  = 0;
      end
    end else begin
      if (cnt_m == 31) busy_m = 1'b0;
      cnt_m = (cnt_m + 1) % 32;
    end
    valid_m[0] = 1'b0;
    valid_m[1] = 1'b0;
    for (int i = pq.size() - 1; i >= 0; i--) begin
      if (pq[i].due == edge_n) begin
        last_m[pq[i].k]  = pq[i].data;
        valid_m[pq[i].k] = 1'b1;
        pq.delete(i);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_idle();
    wr = 1'b0; rd = 1'b0; clr = 1'b0; wbe = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (auto_chk) begin
      chk("busy_a", busy_a, busy_m);
      chk("busy_b", busy_b, busy_m);
      chk("rvalid_a", rvalid_a, valid_m[0]);
      chk("rvalid_b", rvalid_b, valid_m[1]);
      chk("rdata_a", rdata_a, last_m[0]);
      chk("rdata_b", rdata_b, last_m[1]);
    end
  endtask

  task automatic do_write(input int a, input logic [15:0] d);
    set_idle();
    wr = 1'b1; waddr = a[4:0]; wdata = d; wbe = 2'b11;
    step();
    set_idle();
  endtask

  typedef struct {
    logic wr; logic [4:0] waddr; logic [15:0] wdata; logic [1:0] wbe;
    logic rd; logic [4:0] raddr;
    logic va; logic [15:0] da; logic vb; logic [15:0] db;
  } vec_t;
  vec_t tbl [11];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, rvb;
    logic [15:0] vals [4];

    tbl[0]  = '{1'b1, 5'd3, 16'hA55A, 2'b11, 1'b0, 5'd0, 1'b0, 16'hFFFF, 1'b0, 16'h00FF};
    tbl[1]  = '{1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd3, 1'b1, 16'hA55A, 1'b0, 16'h00FF};
    tbl[2]  = '{1'b1, 5'd3, 16'h1234, 2'b01, 1'b0, 5'd0, 1'b0, 16'hA55A, 1'b1, 16'hA55A};
    tbl[3]  = '{1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd3, 1'b1, 16'hA534, 1'b0, 16'hA55A};
    tbl[4]  = '{1'b1, 5'd7, 16'h0000, 2'b11, 1'b0, 5'd0, 1'b0, 16'hA534, 1'b1, 16'hA534};
    tbl[5]  = '{1'b1, 5'd7, 16'hBEEF, 2'b11, 1'b1, 5'd7, 1'b1, 16'h0000, 1'b0, 16'hA534};
    tbl[6]  = '{1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd7, 1'b1, 16'hBEEF, 1'b1, 16'hBEEF};
    tbl[7]  = '{1'b1, 5'd9, 16'h5566, 2'b10, 1'b1, 5'd9, 1'b1, 16'hFFFF, 1'b1, 16'hBEEF};
    tbl[8]  = '{1'b0, 5'd0, 16'h0000, 2'b00, 1'b0, 5'd0, 1'b0, 16'hFFFF, 1'b1, 16'h55FF};
    tbl[9]  = '{1'b1, 5'd9, 16'h0000, 2'b00, 1'b1, 5'd9, 1'b1, 16'h55FF, 1'b0, 16'h55FF};
    tbl[10] = '{1'b0, 5'd0, 16'h0000, 2'b00, 1'b0, 5'd0, 1'b0, 16'h55FF, 1'b1, 16'h55FF};

    // Reset for three cycles.
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_busy_a", busy_a, 0);
    chk("reset_busy_b", busy_b, 0);
    chk("reset_rvalid_a", rvalid_a, 0);
    chk("reset_rvalid_b", rvalid_b, 0);
    chk("reset_rdata_a", rdata_a, 0);
    chk("reset_rdata_b", rdata_b, 0);
    auto_chk = 1'b1;

    // Full clear; reads issued while busy must be dropped.
    clr = 1'b1;
    step();
    clr = 1'b0;
    n = 0;
    rvb = 0;
    while (busy_a && n < 100) begin
      n++;
      rd = 1'b1;
      raddr = n[4:0];
      step();
      if (rvalid_a || rvalid_b) rvb++;
    end
    rd = 1'b0;
    chk("clear_busy_cycles", n, 32);
    chk("rvalid_while_busy", rvb, 0);
    for (int i = 0; i < 32; i++) begin
      rd = 1'b1;
      raddr = i[4:0];
      step();
      chk("clear_readback_a", rdata_a, 16'hFFFF);
    end
    set_idle();
    repeat (3) step();

    // Write, byte enables and collisions.
    for (int i = 0; i < 11; i++) begin
      wr = tbl[i].wr; waddr = tbl[i].waddr; wdata = tbl[i].wdata; wbe = tbl[i].wbe;
      rd = tbl[i].rd; raddr = tbl[i].raddr; clr = 1'b0;
      step();
      chk($sformatf("tbl%0d_rvalid_a", i), rvalid_a, tbl[i].va);
      chk($sformatf("tbl%0d_rdata_a", i), rdata_a, tbl[i].da);
      chk($sformatf("tbl%0d_rvalid_b", i), rvalid_b, tbl[i].vb);
      chk($sformatf("tbl%0d_rdata_b", i), rdata_b, tbl[i].db);
    end
    set_idle();
    step();

    // Back-to-back reads of addresses 0..3.
    for (int i = 0; i < 4; i++) begin
      vals[i] = 16'h1000 + 16'(i * 16'h0111);
      do_write(i, vals[i]);
    end
    for (int j = 0; j < 6; j++) begin
      rd = (j < 4);
      raddr = 5'(j);
      step();
      chk("b2b_rvalid_a", rvalid_a, (j < 4) ? 1 : 0);
      chk("b2b_rdata_a", rdata_a, vals[(j < 4) ? j : 3]);
      chk("b2b_rvalid_b", rvalid_b, (j >= 1 && j <= 4) ? 1 : 0);
      if (j >= 1) chk("b2b_rdata_b", rdata_b, vals[(j <= 4) ? j - 1 : 3]);
    end
    set_idle();

    // clr together with wr and rd in IDLE.
    do_write(5, 16'h1111);
    clr = 1'b1; wr = 1'b1; waddr = 5'd5; wdata = 16'h2222; wbe = 2'b11; rd = 1'b1; raddr = 5'd5;
    step();
    set_idle();
    chk("clr_rd_rvalid_a", rvalid_a, 1);
    chk("clr_rd_rdata_a", rdata_a, 16'h1111);
    chk("clr_rd_busy_a", busy_a, 1);
    step();
    chk("clr_rd_rvalid_b", rvalid_b, 1);
    chk("clr_rd_rdata_b", rdata_b, 16'h2222);
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      step();
    end
    chk("clr_wr_busy_done", busy_a, 0);
    rd = 1'b1; raddr = 5'd5;
    step();
    rd = 1'b0;
    chk("clr_wr_cleared_a", rdata_a, 16'hFFFF);
    step();
    chk("clr_wr_cleared_b", rdata_b, 16'h00FF);

    // Reset in the middle of a clear.
    for (int i = 0; i < 13; i++) do_write(i, 16'h2000 + 16'(i));
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (10) step();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_abort_busy_a", busy_a, 0);
    chk("rst_abort_busy_b", busy_b, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_abort_rdata_a", rdata_a, 0);
    for (int i = 0; i < 13; i++) begin
      rd = 1'b1;
      raddr = 5'(i);
      step();
      chk("rst_abort_word_a", rdata_a, (i < 10) ? 16'hFFFF : 16'h2000 + 16'(i));
    end
    set_idle();
    repeat (2) step();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      wr    = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 31));
      wdata = 16'($urandom);
      wbe   = 2'($urandom_range(0, 3));
      rd    = 1'($urandom_range(0, 1));
      raddr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      clr   = ($urandom_range(0, 63) == 0);
      step();
    end
    set_idle();
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      step();
    end
    repeat (3) step();
    chk("final_busy_a", busy_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
